// File: rtl/dds_pkg.sv
// dds_pkg: shared constants, FSM state and data types for the DDS channel scheduler
package dds_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 24;
  localparam int ROM_LAT = 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] sample_t;
endpackage

// File: rtl/dds_phase_acc_bank.sv
// dds_phase_acc_bank: per-channel FTW registers and phase accumulators, one slot advanced per issue.
// DDS_PHASE_OFFSET_EN adds per-channel address offsets applied to the issued ROM address.
module dds_phase_acc_bank
  import dds_pkg::*;
#(
  parameter int NCH = 4,
  parameter int ACC_W = 32,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic              phase_clr,
  input  logic [CH_W-1:0]   slot,
  input  logic              ftw_wr,
  input  logic [CH_W-1:0]   ftw_ch,
  input  logic [ACC_W-1:0]  ftw_data,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic              off_wr,
  input  logic [CH_W-1:0]   off_ch,
  input  logic [ADDR_W-1:0] off_data,
`endif
  output logic [ADDR_W-1:0] addr
);
  logic [ACC_W-1:0] acc [NCH];
  logic [ACC_W-1:0] ftw [NCH];
`ifdef DDS_PHASE_OFFSET_EN
  addr_t off [NCH];
  assign addr = acc[slot][ACC_W-1 -: ADDR_W] + off[slot];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) off <= '{default: '0};
    else if (off_wr) off[off_ch] <= off_data;
`else
  assign addr = acc[slot][ACC_W-1 -: ADDR_W];
`endif
  // Increment reads the pre-write FTW, so a same-clk write lands on the next visit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '{default: '0};
      ftw <= '{default: '0};
    end else begin
      if (phase_clr) acc <= '{default: '0};
      else if (issue) acc[slot] <= acc[slot] + ftw[slot];
      if (ftw_wr) ftw[ftw_ch] <= ftw_data;
    end
endmodule

// File: rtl/dds_channel_scheduler.sv
// dds_channel_scheduler: round-robin DDS channels sharing one registered-read wavetable ROM.
// DDS_PHASE_OFFSET_EN enables per-channel phase offset ports (off_wr/off_ch/off_data).
module dds_channel_scheduler
  import dds_pkg::*;
#(
  parameter int NCH = 4,
  parameter int ACC_W = 32,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              phase_clr,
  input  logic              ftw_wr,
  input  logic [CH_W-1:0]   ftw_ch,
  input  logic [ACC_W-1:0]  ftw_data,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic              off_wr,
  input  logic [CH_W-1:0]   off_ch,
  input  logic [ADDR_W-1:0] off_data,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] sample_out,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  output logic              busy
);
  localparam int PIPE = ROM_LAT + 1;
  state_t state, state_n;
  logic [CH_W-1:0] slot;
  logic drain_cnt, issue;
  addr_t addr;
  logic [PIPE-1:0] vld_q;
  logic [CH_W-1:0] tag_q [PIPE];
  assign issue = state == RUN;
  dds_phase_acc_bank #(.NCH(NCH), .ACC_W(ACC_W)) u_bank (
    .clk(clk), .rst_n(rst_n), .issue(issue), .phase_clr(phase_clr), .slot(slot),
    .ftw_wr(ftw_wr), .ftw_ch(ftw_ch), .ftw_data(ftw_data),
`ifdef DDS_PHASE_OFFSET_EN
    .off_wr(off_wr), .off_ch(off_ch), .off_data(off_data),
`endif
    .addr(addr)
  );
  always_comb begin
    state_n = state;
    busy = state != IDLE;
    state_n = enable ? RUN : state == RUN ? DRAIN : (state == DRAIN && !drain_cnt) ? DRAIN : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state <= state_n;
      drain_cnt <= state == DRAIN && !drain_cnt;
    end
  // Tag/valid pipe spans the address register plus the ROM read latency.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot <= '0;
      rom_addr <= '0;
      vld_q <= '0;
      tag_q <= '{default: '0};
      sample_out <= '0;
      sample_ch <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (issue) begin
        slot <= slot + 1'b1;
        rom_addr <= addr;
      end
      vld_q <= {vld_q[PIPE-2:0], issue};
      tag_q[0] <= slot;
      for (int i = 1; i < PIPE; i++) tag_q[i] <= tag_q[i-1];
      sample_valid <= vld_q[PIPE-1];
      if (vld_q[PIPE-1]) begin
        sample_out <= rom_dout;
        sample_ch <= tag_q[PIPE-1];
      end
    end
endmodule

// File: tb/tb_dds_channel_scheduler.sv
// tb_dds_channel_scheduler: randomized and directed checks against a queue-based behavioural model.
module tb_dds_channel_scheduler;
  logic clk = 0, rst_n = 0, enable = 0, phase_clr = 0, ftw_wr = 0;
  logic [1:0] ftw_ch = 0;
  logic [31:0] ftw_data = 0;
  logic [11:0] rom_addr;
  logic [23:0] rom_dout = 0, sample_out;
  logic [1:0] sample_ch;
  logic sample_valid, busy;
  int vectors = 0, miscompares = 0;

  dds_channel_scheduler #(.NCH(4), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .phase_clr(phase_clr),
    .ftw_wr(ftw_wr), .ftw_ch(ftw_ch), .ftw_data(ftw_data),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .sample_out(sample_out),
    .sample_ch(sample_ch), .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_dout <= {12'd0, rom_addr};

  typedef struct { int due; int ch; logic [23:0] data; } exp_t;
  exp_t q[$];
  logic [31:0] m_acc[4], m_ftw[4];
  int m_state, m_slot, m_drain, edge_n;
  logic exp_valid, exp_busy;
  logic [1:0] exp_ch;
  logic [23:0] exp_data;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0;
      m_ftw[i] = 0;
    end
    m_state = 0;
    m_slot = 0;
    m_drain = 0;
    q.delete();
  endfunction

  // Advance the model with the inputs currently driven, then one clock; expected outputs land in exp_*.
  task automatic tick();
    exp_t e;
    if (!rst_n) model_reset();
    else begin
      if (m_state == 1) begin
        q.push_back('{edge_n + 3, m_slot, {12'd0, m_acc[m_slot][31:20]}});
        m_acc[m_slot] = m_acc[m_slot] + m_ftw[m_slot];
        m_slot = (m_slot + 1) % 4;
      end
      if (phase_clr) for (int i = 0; i < 4; i++) m_acc[i] = 0;
      if (ftw_wr) m_ftw[ftw_ch] = ftw_data;
      if (enable) m_state = 1;
      else if (m_state == 1) begin
        m_state = 2;
        m_drain = 2;
      end else if (m_state == 2) begin
        m_drain--;
        if (m_drain == 0) m_state = 0;
      end
    end
    @(posedge clk);
    #1;
    edge_n++;
    exp_busy = m_state != 0;
    exp_valid = 0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      e = q.pop_front();
      exp_valid = 1;
      exp_ch = 2'(e.ch);
      exp_data = e.data;
    end
  endtask

  task automatic hard_reset();
    enable = 0;
    phase_clr = 0;
    ftw_wr = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic write_ftw(input int ch, input logic [31:0] d);
    ftw_wr = 1;
    ftw_ch = 2'(ch);
    ftw_data = d;
    tick();
    ftw_wr = 0;
  endtask

  task automatic test_reset();
    hard_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (sample_valid !== 0 || busy !== 0 || sample_out !== 0 || sample_ch !== 0 || rom_addr !== 0) begin
        miscompares++;
        $display("FAIL reset_idle k=%0d got v=%b busy=%b d=%h ch=%0d addr=%h want all 0", k, sample_valid, busy, sample_out, sample_ch, rom_addr);
      end
    end
  endtask

  task automatic test_round_robin();
    int step[4] = '{1, 2, 0, 'hFFF};
    int n = 0;
    logic [11:0] w;
    hard_reset();
    write_ftw(0, 32'h0010_0000);
    write_ftw(1, 32'h0020_0000);
    write_ftw(2, 32'h0000_0000);
    write_ftw(3, 32'hFFF0_0000);
    enable = 1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      vectors++;
      if (sample_valid !== exp_valid || busy !== exp_busy || (exp_valid && (sample_ch !== exp_ch || sample_out !== exp_data))) begin
        miscompares++;
        $display("FAIL rr_model k=%0d got v=%b b=%b ch=%0d d=%h want v=%b b=%b ch=%0d d=%h", k, sample_valid, busy, sample_ch, sample_out, exp_valid, exp_busy, exp_ch, exp_data);
      end
      vectors++;
      if (sample_valid !== (k >= 4)) begin
        miscompares++;
        $display("FAIL rr_first_valid k=%0d got v=%b want %b", k, sample_valid, k >= 4);
      end
      if (sample_valid) begin
        w = 12'((n / 4) * step[n % 4]);
        vectors++;
        if (sample_ch !== 2'(n % 4) || sample_out !== {12'd0, w}) begin
          miscompares++;
          $display("FAIL rr_sequence n=%0d got ch=%0d d=%h want ch=%0d d=%h", n, sample_ch, sample_out, n % 4, w);
        end
        n++;
      end
    end
  endtask

  task automatic test_wrap();
    int v0 = 0;
    hard_reset();
    write_ftw(0, 32'h8000_0000);
    enable = 1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      vectors++;
      if (sample_valid !== exp_valid || busy !== exp_busy || (exp_valid && (sample_ch !== exp_ch || sample_out !== exp_data))) begin
        miscompares++;
        $display("FAIL wrap_model k=%0d got v=%b b=%b ch=%0d d=%h want v=%b b=%b ch=%0d d=%h", k, sample_valid, busy, sample_ch, sample_out, exp_valid, exp_busy, exp_ch, exp_data);
      end
      if (sample_valid && sample_ch == 0) begin
        vectors++;
        if (sample_out !== ((v0 % 2) ? 24'h800 : 24'h000)) begin
          miscompares++;
          $display("FAIL wrap_alt visit=%0d got %h want %h", v0, sample_out, (v0 % 2) ? 24'h800 : 24'h000);
        end
        v0++;
      end
    end
  endtask

  task automatic test_collision();
    int exp2[5] = '{0, 1, 2, 5, 8};
    logic [11:0] got2[$];
    bit hit = 0;
    hard_reset();
    write_ftw(2, 32'h0010_0000);
    enable = 1;
    for (int k = 1; k <= 40; k++) begin
      if (!hit && m_state == 1 && m_slot == 2 && m_acc[2][31:20] == 12'd1) begin
        ftw_wr = 1;
        ftw_ch = 2;
        ftw_data = 32'h0030_0000;
        hit = 1;
      end
      tick();
      ftw_wr = 0;
      vectors++;
      if (sample_valid !== exp_valid || busy !== exp_busy || (exp_valid && (sample_ch !== exp_ch || sample_out !== exp_data))) begin
        miscompares++;
        $display("FAIL coll_model k=%0d got v=%b b=%b ch=%0d d=%h want v=%b b=%b ch=%0d d=%h", k, sample_valid, busy, sample_ch, sample_out, exp_valid, exp_busy, exp_ch, exp_data);
      end
      if (sample_valid && sample_ch == 2) got2.push_back(sample_out[11:0]);
    end
    vectors++;
    if (!hit || got2.size() < 5) begin
      miscompares++;
      $display("FAIL coll_count got hit=%0d samples=%0d want hit=1 samples>=5", hit, got2.size());
    end else
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (got2[i] !== 12'(exp2[i])) begin
          miscompares++;
          $display("FAIL coll_step i=%0d got %h want %h", i, got2[i], exp2[i]);
        end
      end
  endtask

  task automatic test_drain_restart();
    int last = -1, gaps = 0;
    hard_reset();
    for (int c = 0; c < 4; c++) write_ftw(c, $urandom);
    enable = 1;
    for (int k = 1; k <= 36; k++) begin
      enable = (k != 14);
      tick();
      vectors++;
      if (sample_valid !== exp_valid || busy !== exp_busy || (exp_valid && (sample_ch !== exp_ch || sample_out !== exp_data))) begin
        miscompares++;
        $display("FAIL drain_model k=%0d got v=%b b=%b ch=%0d d=%h want v=%b b=%b ch=%0d d=%h", k, sample_valid, busy, sample_ch, sample_out, exp_valid, exp_busy, exp_ch, exp_data);
      end
      if (sample_valid) begin
        if (last >= 0) begin
          vectors++;
          if (sample_ch !== 2'((last + 1) % 4)) begin
            miscompares++;
            $display("FAIL drain_seq k=%0d got ch=%0d want %0d", k, sample_ch, (last + 1) % 4);
          end
        end
        last = sample_ch;
      end else if (last >= 0) gaps++;
    end
    vectors++;
    if (gaps != 1) begin
      miscompares++;
      $display("FAIL drain_gap got %0d idle slots want 1", gaps);
    end
  endtask

  task automatic test_phase_clr();
    hard_reset();
    for (int c = 0; c < 4; c++) write_ftw(c, 32'h0010_0000 * (c + 1));
    enable = 1;
    for (int k = 1; k <= 15; k++) tick();
    for (int j = 0; j <= 16; j++) begin
      phase_clr = (j == 0);
      ftw_wr = (j == 0);
      ftw_ch = 0;
      ftw_data = 32'h0050_0000;
      tick();
      phase_clr = 0;
      ftw_wr = 0;
      vectors++;
      if (sample_valid !== exp_valid || busy !== exp_busy || (exp_valid && (sample_ch !== exp_ch || sample_out !== exp_data))) begin
        miscompares++;
        $display("FAIL clr_model j=%0d got v=%b b=%b ch=%0d d=%h want v=%b b=%b ch=%0d d=%h", j, sample_valid, busy, sample_ch, sample_out, exp_valid, exp_busy, exp_ch, exp_data);
      end
      if (j >= 3 && j <= 6) begin
        vectors++;
        if (sample_valid !== 1 || sample_out !== 0) begin
          miscompares++;
          $display("FAIL clr_zero j=%0d got v=%b d=%h want v=1 d=0", j, sample_valid, sample_out);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    hard_reset();
    for (int c = 0; c < 4; c++) write_ftw(c, $urandom);
    enable = 1;
    for (int k = 1; k <= 15; k++) tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    vectors++;
    if (sample_valid !== 0 || busy !== 0 || sample_out !== 0 || sample_ch !== 0 || rom_addr !== 0) begin
      miscompares++;
      $display("FAIL async_reset got v=%b busy=%b d=%h ch=%0d addr=%h want all 0", sample_valid, busy, sample_out, sample_ch, rom_addr);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (sample_valid !== 0 || busy !== 0) begin
        miscompares++;
        $display("FAIL reset_hold k=%0d got v=%b busy=%b want 0 0", k, sample_valid, busy);
      end
    end
    rst_n = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vectors++;
      if (sample_valid !== exp_valid || busy !== exp_busy || (exp_valid && (sample_ch !== exp_ch || sample_out !== exp_data))) begin
        miscompares++;
        $display("FAIL rst_model k=%0d got v=%b b=%b ch=%0d d=%h want v=%b b=%b ch=%0d d=%h", k, sample_valid, busy, sample_ch, sample_out, exp_valid, exp_busy, exp_ch, exp_data);
      end
      vectors++;
      if (sample_valid !== (k >= 4) || (sample_valid && sample_out !== 0)) begin
        miscompares++;
        $display("FAIL rst_restart k=%0d got v=%b d=%h want v=%b d=0", k, sample_valid, sample_out, k >= 4);
      end
    end
  endtask

  task automatic test_random();
    hard_reset();
    for (int k = 1; k <= 1500; k++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      phase_clr = $urandom_range(0, 49) == 0;
      ftw_wr = $urandom_range(0, 5) == 0;
      ftw_ch = 2'($urandom_range(0, 3));
      ftw_data = $urandom;
      tick();
      vectors++;
      if (sample_valid !== exp_valid || busy !== exp_busy || (exp_valid && (sample_ch !== exp_ch || sample_out !== exp_data))) begin
        miscompares++;
        $display("FAIL rand_model k=%0d got v=%b b=%b ch=%0d d=%h want v=%b b=%b ch=%0d d=%h", k, sample_valid, busy, sample_ch, sample_out, exp_valid, exp_busy, exp_ch, exp_data);
      end
    end
    phase_clr = 0;
    ftw_wr = 0;
  endtask

  initial begin
    edge_n = 0;
    model_reset();
    test_reset();
    test_round_robin();
    test_wrap();
    test_collision();
    test_drain_restart();
    test_phase_clr();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
